sample_ftw_ctrl: RTL and testbench

SAMPLE_FTW_CTRL -- requirements
Module: sample_ftw_ctrl

---
 rtl/sample_ftw_ctrl.sv | 172 +++++++++++++++++
 tb/tb_sample_ftw_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_ftw_ctrl.sv
// Sampling-NCO frequency tuning word controller.
// The host loads a nominal FTW and an offset limit. After a fixed number of
// symbol strobes for settling, timing-error corrections are accumulated into
// a pending offset. That offset is applied, saturated to +/-limit, at each
// symbol strobe.
module sample_ftw_ctrl #(
  parameter int unsigned SETTLE_SYMS = 16,
  parameter int unsigned DELTA_W     = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [31:0]        cfg_ftw,
  input  logic [30:0]        cfg_limit,
  input  logic               corr_valid,
  input  logic [DELTA_W-1:0] corr_delta,
  input  logic               sym_strobe,
  output logic [31:0]        o_sample_ftw,
  output logic               o_nco_rst,
  output logic               o_locked,
  output logic               o_clamp,
  output logic [1:0]         o_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_TRACK  = 2'd3
  } state_t;

  localparam int unsigned CNT_W = (SETTLE_SYMS > 1) ? $clog2(SETTLE_SYMS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((SETTLE_SYMS > 0) ? SETTLE_SYMS - 1 : 0);

  localparam logic signed [33:0] S32_MAX = 34'sh0_7FFF_FFFF;
  localparam logic signed [33:0] S32_MIN = 34'sh3_8000_0000;

  state_t                state_q, state_d;
  logic [31:0]           nominal_q, nominal_d;
  logic [30:0]           limit_q, limit_d;
  logic signed [31:0]    offset_q, offset_d;
  logic signed [31:0]    pending_q, pending_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [31:0]           ftw_q, ftw_d;
  logic                  clamp_q, clamp_d;

  logic                  handshake;
  logic signed [DELTA_W-1:0] delta_s;
  logic signed [33:0]    delta34;
  logic signed [33:0]    pend_sum34;
  logic signed [31:0]    pend_sat;
  logic signed [33:0]    sum34;
  logic signed [33:0]    lim34;
  logic signed [33:0]    clamped34;
  logic                  clip;
  logic [31:0]           clamped32;

  assign cfg_ready    = ~rst & (state_q != ST_LOAD);
  assign handshake    = cfg_valid & cfg_ready;
  assign o_nco_rst    = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign o_locked     = (state_q == ST_TRACK);
  assign o_state      = state_q;
  assign o_sample_ftw = ftw_q;
  assign o_clamp      = clamp_q;

  assign delta_s = corr_delta;
  assign delta34 = 34'(delta_s);

  // Correction accumulation and strobe-time offset arithmetic (34-bit, no overflow)
  always_comb begin
    pend_sum34 = 34'(pending_q) + delta34;
    if (pend_sum34 > S32_MAX) begin
      pend_sat = 32'sh7FFF_FFFF;
    end else if (pend_sum34 < S32_MIN) begin
      pend_sat = 32'sh8000_0000;
    end else begin
      pend_sat = pend_sum34[31:0];
    end

    sum34 = 34'(offset_q) + 34'(pending_q) + (corr_valid ? delta34 : 34'sd0);
    lim34 = signed'({3'b000, limit_q});
    clip  = 1'b0;
    if (sum34 > lim34) begin
      clamped34 = lim34;
      clip      = 1'b1;
    end else if (sum34 < -lim34) begin
      clamped34 = -lim34;
      clip      = 1'b1;
    end else begin
      clamped34 = sum34;
    end
    clamped32 = clamped34[31:0];
  end

  // Next-state and register-update decode; a config handshake overrides all activity
  always_comb begin
    state_d   = state_q;
    nominal_d = nominal_q;
    limit_d   = limit_q;
    offset_d  = offset_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    ftw_d     = ftw_q;
    clamp_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
      end
      ST_LOAD: begin
        state_d = ST_SETTLE;
        cnt_d   = '0;
      end
      ST_SETTLE: begin
        if (sym_strobe) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_TRACK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_TRACK: begin
        if (sym_strobe) begin
          offset_d  = signed'(clamped32);
          pending_d = '0;
          ftw_d     = nominal_q + clamped32;
          clamp_d   = clip;
        end else if (corr_valid) begin
          pending_d = pend_sat;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (handshake) begin
      nominal_d = cfg_ftw;
      limit_d   = cfg_limit;
      offset_d  = '0;
      pending_d = '0;
      cnt_d     = '0;
      ftw_d     = cfg_ftw;
      clamp_d   = 1'b0;
      state_d   = ST_LOAD;
    end
  end

  // State and datapath registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      nominal_q <= '0;
      limit_q   <= '0;
      offset_q  <= '0;
      pending_q <= '0;
      cnt_q     <= '0;
      ftw_q     <= '0;
      clamp_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      nominal_q <= nominal_d;
      limit_q   <= limit_d;
      offset_q  <= offset_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      ftw_q     <= ftw_d;
      clamp_q   <= clamp_d;
    end
  end

endmodule

// File: tb/tb_sample_ftw_ctrl.sv
// Directed self-checking bench for sample_ftw_ctrl.
module tb_sample_ftw_ctrl;

  logic        clk;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_ftw;
  logic [30:0] cfg_limit;
  logic        corr_valid;
  logic [23:0] corr_delta;
  logic        sym_strobe;
  logic [31:0] o_sample_ftw;
  logic        o_nco_rst;
  logic        o_locked;
  logic        o_clamp;
  logic [1:0]  o_state;

  int n_checks;
  int n_fail;

  sample_ftw_ctrl #(.SETTLE_SYMS(16), .DELTA_W(24)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_ftw      (cfg_ftw),
    .cfg_limit    (cfg_limit),
    .corr_valid   (corr_valid),
    .corr_delta   (corr_delta),
    .sym_strobe   (sym_strobe),
    .o_sample_ftw (o_sample_ftw),
    .o_nco_rst    (o_nco_rst),
    .o_locked     (o_locked),
    .o_clamp      (o_clamp),
    .o_state      (o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input logic [31:0] ftw, input logic [30:0] lim);
    cfg_valid = 1'b1;
    cfg_ftw   = ftw;
    cfg_limit = lim;
    tick();
    cfg_valid = 1'b0;
  endtask

  // n strobes separated by idle cycles; optional correction on each strobe cycle
  task automatic strobes(input int n, input logic with_corr);
    for (int i = 0; i < n; i++) begin
      sym_strobe = 1'b1;
      corr_valid = with_corr;
      corr_delta = 24'd500;
      tick();
      sym_strobe = 1'b0;
      corr_valid = 1'b0;
      tick();
    end
  endtask

  task automatic corr(input logic [23:0] d);
    corr_valid = 1'b1;
    corr_delta = d;
    tick();
    corr_valid = 1'b0;
  endtask

  task automatic strobe_once();
    sym_strobe = 1'b1;
    tick();
    sym_strobe = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (o_sample_ftw !== 32'h0) begin n_fail++; $display("FAIL reset_ftw got %h exp %h", o_sample_ftw, 32'h0); end
    n_checks++; if (o_nco_rst !== 1'b1) begin n_fail++; $display("FAIL reset_nco_rst got %b exp 1", o_nco_rst); end
    n_checks++; if (o_locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked got %b exp 0", o_locked); end
    n_checks++; if (o_clamp !== 1'b0) begin n_fail++; $display("FAIL reset_clamp got %b exp 0", o_clamp); end
    n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b exp 0", cfg_ready); end
    n_checks++; if (o_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", o_state); end
    rst = 1'b0;
    #1;
    n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready got %b exp 1", cfg_ready); end
  endtask

  task automatic test_config_settle();
    configure(32'h0A3D70A4, 31'h100000);
    n_checks++; if (o_sample_ftw !== 32'h0A3D70A4) begin n_fail++; $display("FAIL cfg_ftw got %h exp %h", o_sample_ftw, 32'h0A3D70A4); end
    n_checks++; if (o_state !== 2'd1) begin n_fail++; $display("FAIL cfg_state_load got %0d exp 1", o_state); end
    n_checks++; if (o_nco_rst !== 1'b1) begin n_fail++; $display("FAIL load_nco_rst got %b exp 1", o_nco_rst); end
    n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL load_ready got %b exp 0", cfg_ready); end
    tick();
    n_checks++; if (o_state !== 2'd2) begin n_fail++; $display("FAIL settle_state got %0d exp 2", o_state); end
    n_checks++; if (o_nco_rst !== 1'b0) begin n_fail++; $display("FAIL settle_nco_rst got %b exp 0", o_nco_rst); end
    strobes(15, 1'b1);
    n_checks++; if (o_locked !== 1'b0) begin n_fail++; $display("FAIL locked_after15 got %b exp 0", o_locked); end
    sym_strobe = 1'b1;
    corr_valid = 1'b1;
    corr_delta = 24'd500;
    tick();
    sym_strobe = 1'b0;
    corr_valid = 1'b0;
    n_checks++; if (o_locked !== 1'b1) begin n_fail++; $display("FAIL locked_after16 got %b exp 1", o_locked); end
    n_checks++; if (o_state !== 2'd3) begin n_fail++; $display("FAIL track_state got %0d exp 3", o_state); end
    n_checks++; if (o_sample_ftw !== 32'h0A3D70A4) begin n_fail++; $display("FAIL settle_ftw got %h exp %h", o_sample_ftw, 32'h0A3D70A4); end
  endtask

  task automatic test_track_accum();
    corr(24'd100);
    corr(24'd50);
    n_checks++; if (o_sample_ftw !== 32'h0A3D70A4) begin n_fail++; $display("FAIL ftw_before_strobe got %h exp %h", o_sample_ftw, 32'h0A3D70A4); end
    strobe_once();
    n_checks++; if (o_sample_ftw !== 32'h0A3D713A) begin n_fail++; $display("FAIL accum_ftw got %h exp %h", o_sample_ftw, 32'h0A3D713A); end
    n_checks++; if (o_clamp !== 1'b0) begin n_fail++; $display("FAIL accum_clamp got %b exp 0", o_clamp); end
  endtask

  task automatic test_clamp();
    corr(24'h200000);
    strobe_once();
    n_checks++; if (o_sample_ftw !== 32'h0A4D70A4) begin n_fail++; $display("FAIL clamp_pos_ftw got %h exp %h", o_sample_ftw, 32'h0A4D70A4); end
    n_checks++; if (o_clamp !== 1'b1) begin n_fail++; $display("FAIL clamp_pos_pulse got %b exp 1", o_clamp); end
    tick();
    n_checks++; if (o_clamp !== 1'b0) begin n_fail++; $display("FAIL clamp_pos_end got %b exp 0", o_clamp); end
    corr(-24'sh300000);
    strobe_once();
    n_checks++; if (o_sample_ftw !== 32'h0A2D70A4) begin n_fail++; $display("FAIL clamp_neg_ftw got %h exp %h", o_sample_ftw, 32'h0A2D70A4); end
    n_checks++; if (o_clamp !== 1'b1) begin n_fail++; $display("FAIL clamp_neg_pulse got %b exp 1", o_clamp); end
    tick();
    n_checks++; if (o_clamp !== 1'b0) begin n_fail++; $display("FAIL clamp_neg_end got %b exp 0", o_clamp); end
  endtask

  task automatic test_same_cycle_strobe();
    corr(24'd30);
    sym_strobe = 1'b1;
    corr_valid = 1'b1;
    corr_delta = -24'sd10;
    tick();
    sym_strobe = 1'b0;
    corr_valid = 1'b0;
    n_checks++; if (o_sample_ftw !== 32'h0A2D70B8) begin n_fail++; $display("FAIL same_cycle_ftw got %h exp %h", o_sample_ftw, 32'h0A2D70B8); end
    n_checks++; if (o_clamp !== 1'b0) begin n_fail++; $display("FAIL same_cycle_clamp got %b exp 0", o_clamp); end
    strobe_once();
    n_checks++; if (o_sample_ftw !== 32'h0A2D70B8) begin n_fail++; $display("FAIL pending_cleared_ftw got %h exp %h", o_sample_ftw, 32'h0A2D70B8); end
  endtask

  task automatic test_reconfig_coincident();
    cfg_valid  = 1'b1;
    cfg_ftw    = 32'h14000000;
    cfg_limit  = 31'h100000;
    corr_valid = 1'b1;
    corr_delta = 24'h001000;
    sym_strobe = 1'b1;
    tick();
    cfg_valid  = 1'b0;
    corr_valid = 1'b0;
    sym_strobe = 1'b0;
    n_checks++; if (o_sample_ftw !== 32'h14000000) begin n_fail++; $display("FAIL reconf_ftw got %h exp %h", o_sample_ftw, 32'h14000000); end
    n_checks++; if (o_state !== 2'd1) begin n_fail++; $display("FAIL reconf_state got %0d exp 1", o_state); end
    n_checks++; if (o_locked !== 1'b0) begin n_fail++; $display("FAIL reconf_locked got %b exp 0", o_locked); end
    n_checks++; if (o_clamp !== 1'b0) begin n_fail++; $display("FAIL reconf_clamp got %b exp 0", o_clamp); end
    tick();
    n_checks++; if (o_state !== 2'd2) begin n_fail++; $display("FAIL reconf_settle got %0d exp 2", o_state); end
    strobes(16, 1'b0);
    n_checks++; if (o_locked !== 1'b1) begin n_fail++; $display("FAIL reconf_relock got %b exp 1", o_locked); end
    strobe_once();
    n_checks++; if (o_sample_ftw !== 32'h14000000) begin n_fail++; $display("FAIL reconf_offset0 got %h exp %h", o_sample_ftw, 32'h14000000); end
  endtask

  task automatic test_limit_zero();
    configure(32'h20000000, 31'd0);
    tick();
    strobes(16, 1'b0);
    corr(24'd1000);
    strobe_once();
    n_checks++; if (o_sample_ftw !== 32'h20000000) begin n_fail++; $display("FAIL lim0_ftw got %h exp %h", o_sample_ftw, 32'h20000000); end
    n_checks++; if (o_clamp !== 1'b1) begin n_fail++; $display("FAIL lim0_clamp got %b exp 1", o_clamp); end
  endtask

  task automatic test_pending_saturation();
    configure(32'h10000000, 31'h7FFFFFFF);
    tick();
    strobes(16, 1'b0);
    corr_valid = 1'b1;
    corr_delta = 24'h7FFFFF;
    for (int i = 0; i < 300; i++) tick();
    corr_valid = 1'b0;
    strobe_once();
    n_checks++; if (o_sample_ftw !== 32'h8FFFFFFF) begin n_fail++; $display("FAIL sat_ftw got %h exp %h", o_sample_ftw, 32'h8FFFFFFF); end
    n_checks++; if (o_clamp !== 1'b0) begin n_fail++; $display("FAIL sat_clamp got %b exp 0", o_clamp); end
  endtask

  task automatic test_reset_mid_track();
    n_checks++; if (o_locked !== 1'b1) begin n_fail++; $display("FAIL pre_rst_locked got %b exp 1", o_locked); end
    rst        = 1'b1;
    corr_valid = 1'b1;
    corr_delta = 24'd5;
    sym_strobe = 1'b1;
    cfg_valid  = 1'b1;
    #1;
    n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready_comb got %b exp 0", cfg_ready); end
    tick();
    corr_valid = 1'b0;
    sym_strobe = 1'b0;
    cfg_valid  = 1'b0;
    n_checks++; if (o_sample_ftw !== 32'h0) begin n_fail++; $display("FAIL midrst_ftw got %h exp %h", o_sample_ftw, 32'h0); end
    n_checks++; if (o_nco_rst !== 1'b1) begin n_fail++; $display("FAIL midrst_nco got %b exp 1", o_nco_rst); end
    n_checks++; if (o_locked !== 1'b0) begin n_fail++; $display("FAIL midrst_locked got %b exp 0", o_locked); end
    n_checks++; if (o_state !== 2'd0) begin n_fail++; $display("FAIL midrst_state got %0d exp 0", o_state); end
    rst = 1'b0;
    tick();
    n_checks++; if (o_state !== 2'd0) begin n_fail++; $display("FAIL post_rst_idle got %0d exp 0", o_state); end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    cfg_valid  = 1'b0;
    cfg_ftw    = '0;
    cfg_limit  = '0;
    corr_valid = 1'b0;
    corr_delta = '0;
    sym_strobe = 1'b0;
    test_reset();
    test_config_settle();
    test_track_accum();
    test_clamp();
    test_same_cycle_strobe();
    test_reconfig_coincident();
    test_limit_zero();
    test_pending_saturation();
    test_reset_mid_track();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
